// File: rtl/uart_boot_loader.sv
// UART boot loader: receives 8N1 bytes, reads a 32-bit little-endian word count,
// then writes the following little-endian words to consecutive addresses while holding the CPU.
module uart_boot_loader #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_write,
  output logic        cpu_hold,
  output logic        done,
  output logic        frame_error
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {HDR, LOAD, DONE} ld_state_t;

  logic [1:0]    sync_q;
  logic          rx_s;
  rx_state_t     rx_state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;

  ld_state_t     ld_state_q;
  logic [1:0]    byte_idx_q;
  logic [23:0]   asm_q;
  logic [31:0]   word_count_q;
  logic [31:0]   words_q;
  logic [31:0]   mem_address_q;
  logic [31:0]   mem_data_q;
  logic          mem_write_q;
  logic          done_q;
  logic          cpu_hold_q;
  logic          frame_error_q;

  logic          timer_half_d;
  logic          timer_full_d;
  logic          byte_valid_d;
  logic          stop_bad_d;
  logic [31:0]   word_d;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  always_comb begin
    timer_half_d = (timer_q == HALF_M1);
    timer_full_d = (timer_q == FULL_M1);
    byte_valid_d = (rx_state_q == STOP) && timer_full_d && rx_s;
    stop_bad_d   = (rx_state_q == STOP) && timer_full_d && !rx_s;
    // Completed word when the 4th byte arrives: earlier bytes sit in asm_q[23:0].
    word_d       = {shift_q, asm_q};
  end

  // Receiver: samples mid-bit, half a bit after the start edge, then every full bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      case (rx_state_q)
        IDLE: begin
          timer_q   <= '0;
          bit_cnt_q <= '0;
          if (!rx_s) rx_state_q <= START;
        end
        START: begin
          if (timer_half_d) begin
            timer_q    <= '0;
            rx_state_q <= rx_s ? IDLE : DATA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DATA: begin
          if (timer_full_d) begin
            timer_q   <= '0;
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) rx_state_q <= STOP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        STOP: begin
          if (timer_full_d) begin
            timer_q    <= '0;
            rx_state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: rx_state_q <= IDLE;
      endcase
    end
  end

  // Loader: header word count, then word packing and memory writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_q    <= HDR;
      byte_idx_q    <= '0;
      asm_q         <= '0;
      word_count_q  <= '0;
      words_q       <= '0;
      mem_address_q <= BASE_ADDR;
      mem_data_q    <= '0;
      mem_write_q   <= 1'b0;
      done_q        <= 1'b0;
      cpu_hold_q    <= 1'b1;
      frame_error_q <= 1'b0;
    end else begin
      mem_write_q <= 1'b0;
      cpu_hold_q  <= !done_q;
      if (mem_write_q) mem_address_q <= mem_address_q + 32'd4;
      if (stop_bad_d && ld_state_q != DONE) frame_error_q <= 1'b1;
      case (ld_state_q)
        HDR: begin
          if (byte_valid_d) begin
            if (byte_idx_q == 2'd3) begin
              byte_idx_q   <= '0;
              word_count_q <= word_d;
              if (word_d == 32'd0) begin
                ld_state_q <= DONE;
                done_q     <= 1'b1;
              end else begin
                ld_state_q <= LOAD;
              end
            end else begin
              asm_q      <= {shift_q, asm_q[23:8]};
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end
        end
        LOAD: begin
          if (byte_valid_d) begin
            if (byte_idx_q == 2'd3) begin
              byte_idx_q  <= '0;
              mem_data_q  <= word_d;
              mem_write_q <= 1'b1;
              words_q     <= words_q + 32'd1;
              if (words_q == word_count_q - 32'd1) begin
                ld_state_q <= DONE;
                done_q     <= 1'b1;
              end
            end else begin
              asm_q      <= {shift_q, asm_q[23:8]};
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end
        end
        DONE:    ld_state_q <= DONE;
        default: ld_state_q <= HDR;
      endcase
    end
  end

  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_write   = mem_write_q;
  assign cpu_hold    = cpu_hold_q;
  assign done        = done_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: directed UART frames, expected writes queued,
// a negedge monitor pops and compares every mem_write.
module tb_uart_boot_loader;

  localparam int C = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx0 = 1'b1;
  logic        rx1 = 1'b1;
  logic [31:0] mem_address0, mem_data0, mem_address1, mem_data1;
  logic        mem_write0, cpu_hold0, done0, frame_error0;
  logic        mem_write1, cpu_hold1, done1, frame_error1;

  int checks = 0;
  int errors = 0;
  wr_t q0[$];
  wr_t q1[$];
  logic prev_w0 = 1'b0;
  logic prev_w1 = 1'b0;

  always #5 clk = ~clk;

  uart_boot_loader #(.CLKS_PER_BIT(C), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .rx(rx0),
    .mem_address(mem_address0), .mem_data(mem_data0), .mem_write(mem_write0),
    .cpu_hold(cpu_hold0), .done(done0), .frame_error(frame_error0)
  );

  uart_boot_loader #(.CLKS_PER_BIT(C), .BASE_ADDR(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .rx(rx1),
    .mem_address(mem_address1), .mem_data(mem_data1), .mem_write(mem_write1),
    .cpu_hold(cpu_hold1), .done(done1), .frame_error(frame_error1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of its queue and last exactly one cycle.
  always @(negedge clk) begin
    wr_t e;
    if (prev_w0) chk("dut0_write_width", {31'd0, mem_write0}, 32'd0);
    if (prev_w1) chk("dut1_write_width", {31'd0, mem_write1}, 32'd0);
    if (mem_write0) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_write", mem_address0, 32'hxxxx_xxxx);
      end else begin
        e = q0.pop_front();
        $display("dut0 write %h @ %h (expected %h @ %h)", mem_data0, mem_address0, e.data, e.addr);
        chk("dut0_addr", mem_address0, e.addr);
        chk("dut0_data", mem_data0, e.data);
      end
    end
    if (mem_write1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_write", mem_address1, 32'hxxxx_xxxx);
      end else begin
        e = q1.pop_front();
        $display("dut1 write %h @ %h (expected %h @ %h)", mem_data1, mem_address1, e.data, e.addr);
        chk("dut1_addr", mem_address1, e.addr);
        chk("dut1_data", mem_data1, e.data);
      end
    end
    prev_w0 = mem_write0;
    prev_w1 = mem_write1;
  end

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else          rx1 = v;
  endtask

  task automatic send_bit(input int sel, input logic v);
    drive(sel, v);
    repeat (C) @(negedge clk);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic stopv);
    logic [7:0] bb;
    bb = b;
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, bb[i]);
    send_bit(sel, stopv);
    drive(sel, 1'b1);
    if (!stopv) repeat (2 * C) @(negedge clk);
  endtask

  task automatic send_word(input int sel, input logic [31:0] w);
    logic [31:0] ww;
    ww = w;
    for (int i = 0; i < 4; i++) send_byte(sel, ww[8*i +: 8], 1'b1);
  endtask

  task automatic push0(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    q1.push_back(e);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_addr"},  mem_address0, 32'h0);
    chk({tag, "_data"},  mem_data0, 32'h0);
    chk({tag, "_write"}, {31'd0, mem_write0}, 32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_hold0}, 32'd1);
    chk({tag, "_done"},  {31'd0, done0}, 32'd0);
    chk({tag, "_ferr"},  {31'd0, frame_error0}, 32'd0);
  endtask

  task automatic check_end0(input string tag, input logic fe);
    repeat (8) @(negedge clk);
    chk({tag, "_done"}, {31'd0, done0}, 32'd1);
    chk({tag, "_hold"}, {31'd0, cpu_hold0}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, frame_error0}, {31'd0, fe});
    chk({tag, "_pending"}, q0.size(), 32'd0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check_reset_state("reset");
    chk("reset_dut1_addr", mem_address1, 32'hFFFF_FFFC);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-word load.
    push0(32'h0, 32'h1234_5678);
    push0(32'h4, 32'hDEAD_BEEF);
    send_word(0, 32'd2);
    chk("basic_hold_during", {31'd0, cpu_hold0}, 32'd1);
    send_word(0, 32'h1234_5678);
    send_word(0, 32'hDEAD_BEEF);
    check_end0("basic", 1'b0);

    // Zero-length image, then ignored traffic.
    pulse_reset();
    send_word(0, 32'd0);
    check_end0("zero", 1'b0);
    send_word(0, 32'hA5A5_5A5A);
    send_byte(0, 8'h3C, 1'b0);
    check_end0("zero_after", 1'b0);

    // Framing error on first data byte is dropped.
    pulse_reset();
    push0(32'h0, 32'h4433_2211);
    send_word(0, 32'd1);
    send_byte(0, 8'hAA, 1'b0);
    chk("ferr_set", {31'd0, frame_error0}, 32'd1);
    send_word(0, 32'h4433_2211);
    check_end0("ferr", 1'b1);

    // 5-cycle glitch while idle.
    pulse_reset();
    rx0 = 1'b0;
    repeat (5) @(negedge clk);
    rx0 = 1'b1;
    repeat (3 * C) @(negedge clk);
    chk("glitch_ferr", {31'd0, frame_error0}, 32'd0);
    chk("glitch_done", {31'd0, done0}, 32'd0);
    push0(32'h0, 32'hCAFE_0001);
    send_word(0, 32'd1);
    send_word(0, 32'hCAFE_0001);
    check_end0("glitch", 1'b0);

    // Reset mid-image.
    pulse_reset();
    push0(32'h0, 32'h0403_0201);
    send_word(0, 32'd3);
    send_word(0, 32'h0403_0201);
    send_byte(0, 8'h55, 1'b1);
    send_byte(0, 8'h66, 1'b1);
    chk("midrst_addr_before", mem_address0, 32'h4);
    pulse_reset();
    check_reset_state("midrst");
    push0(32'h0, 32'hD4C3_B2A1);
    send_word(0, 32'd1);
    send_word(0, 32'hD4C3_B2A1);
    check_end0("midrst", 1'b0);

    // Address wrap on the second instance.
    pulse_reset();
    push1(32'hFFFF_FFFC, 32'hCAFE_F00D);
    push1(32'h0000_0000, 32'h0102_0304);
    send_word(1, 32'd2);
    send_word(1, 32'hCAFE_F00D);
    send_word(1, 32'h0102_0304);
    repeat (8) @(negedge clk);
    chk("wrap_done", {31'd0, done1}, 32'd1);
    chk("wrap_hold", {31'd0, cpu_hold1}, 32'd0);
    chk("wrap_pending", q1.size(), 32'd0);
    chk("wrap_dut0_pending", q0.size(), 32'd0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
